// File: rtl/scalar_writeback_arbiter_pkg.sv
// Shared types for the scalar register-file writeback path: write entry layout
// and the per-cycle source-select encoding.
package scalar_wb_pkg;

    localparam int REGISTERS_DEFAULT = 32;
    localparam int WIDTH_DEFAULT     = 32;
    localparam int ADDR_W_DEFAULT    = $clog2(REGISTERS_DEFAULT);

    typedef logic [ADDR_W_DEFAULT-1:0] reg_addr_t;

    typedef struct packed {
        reg_addr_t                addr;
        logic [WIDTH_DEFAULT-1:0] data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_ALU,
        SRC_MEM,
        SRC_FORCE
    } wb_src_t;

endpackage

// File: rtl/scalar_writeback_arbiter_fifo.sv
// Small synchronous FIFO of pending writeback entries. Every slot is visible
// with its valid flag so the owner can search for in-flight destinations.
module wb_fifo
    import scalar_wb_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = wb_entry_t
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  entry_t           push_entry,
    input  logic             pop,
    output entry_t           head,
    output logic             full,
    output logic             empty,
    output logic [DEPTH-1:0] entry_valid,
    output entry_t           entries [DEPTH]
);

    localparam int PTR_W = $clog2(DEPTH);

    entry_t           mem_reg [DEPTH];
    logic [PTR_W:0]   wr_ptr_reg;
    logic [PTR_W:0]   rd_ptr_reg;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    // Extra wrap bit distinguishes full from empty when the low bits match.
    assign count   = wr_ptr_reg - rd_ptr_reg;
    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                     (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem_reg[rd_ptr_reg[PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_reg[wr_ptr_reg[PTR_W-1:0]] <= push_entry;
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            logic [PTR_W-1:0] offset;
            assign offset          = PTR_W'(gi) - rd_ptr_reg[PTR_W-1:0];
            assign entry_valid[gi] = ({1'b0, offset} < count);
            assign entries[gi]     = mem_reg[gi];
        end
    endgenerate

endmodule

// File: rtl/scalar_writeback_arbiter.sv
// Single write-port driver for the scalar register file: ALU results win,
// buffered loads retire in order and are forced through after MAX_WAIT bypasses.
module scalar_writeback_arbiter
    import scalar_wb_pkg::*;
#(
    parameter int REGISTERS  = REGISTERS_DEFAULT,
    parameter int WIDTH      = WIDTH_DEFAULT,
    parameter int DEPTH      = 4,
    parameter int MAX_WAIT   = 3,
    parameter int DISCARD_R0 = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         alu_valid,
    output logic                         alu_ready,
    input  logic [$clog2(REGISTERS)-1:0] alu_rd,
    input  logic [WIDTH-1:0]             alu_data,
    input  logic                         mem_valid,
    output logic                         mem_ready,
    input  logic [$clog2(REGISTERS)-1:0] mem_rd,
    input  logic [WIDTH-1:0]             mem_data,
    output logic                         we3,
    output logic [$clog2(REGISTERS)-1:0] a3,
    output logic [WIDTH-1:0]             wd3,
    input  logic [$clog2(REGISTERS)-1:0] q_addr,
    output logic                         q_pending
);

    localparam int ADDR_W = $clog2(REGISTERS);
    localparam int CNT_W  = $clog2(MAX_WAIT + 2);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [WIDTH-1:0]  data;
    } entry_t;

    wb_src_t           src;
    entry_t            push_entry;
    entry_t            head;
    entry_t            sel_entry;
    entry_t            entries [DEPTH];
    logic [DEPTH-1:0]  entry_valid;
    logic [DEPTH-1:0]  fifo_hit;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic              force_head;
    logic              discard;
    logic              write_sel;
    logic [CNT_W-1:0]  wait_cnt_reg;
    logic              we3_reg;
    logic [ADDR_W-1:0] a3_reg;
    logic [WIDTH-1:0]  wd3_reg;

    assign mem_ready  = rst_n && !fifo_full;
    assign push       = mem_valid && mem_ready;
    assign push_entry = '{addr: mem_rd, data: mem_data};

    wb_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (push),
        .push_entry  (push_entry),
        .pop         (pop),
        .head        (head),
        .full        (fifo_full),
        .empty       (fifo_empty),
        .entry_valid (entry_valid),
        .entries     (entries)
    );

    assign force_head = !fifo_empty && (wait_cnt_reg >= CNT_W'(MAX_WAIT));

    always_comb begin
        src       = SRC_NONE;
        alu_ready = 1'b0;
        if (rst_n) begin
            alu_ready = 1'b1;
            if (force_head) begin
                src       = SRC_FORCE;
                alu_ready = 1'b0;
            end else if (alu_valid) begin
                src = SRC_ALU;
            end else if (!fifo_empty) begin
                src = SRC_MEM;
            end
        end
    end

    assign pop       = (src == SRC_MEM) || (src == SRC_FORCE);
    assign sel_entry = (src == SRC_ALU) ? entry_t'{addr: alu_rd, data: alu_data} : head;
    // Register 0 results are still consumed so producers never stall on them.
    assign discard   = (DISCARD_R0 != 0) && (sel_entry.addr == '0);
    assign write_sel = (src != SRC_NONE) && !discard;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt_reg <= '0;
        end else if (pop || fifo_empty) begin
            wait_cnt_reg <= '0;
        end else if (src == SRC_ALU && wait_cnt_reg < CNT_W'(MAX_WAIT)) begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            we3_reg <= 1'b0;
            a3_reg  <= '0;
            wd3_reg <= '0;
        end else begin
            we3_reg <= write_sel;
            if (write_sel) begin
                a3_reg  <= sel_entry.addr;
                wd3_reg <= sel_entry.data;
            end
        end
    end

    assign we3 = we3_reg;
    assign a3  = a3_reg;
    assign wd3 = wd3_reg;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
            assign fifo_hit[gi] = entry_valid[gi] && (entries[gi].addr == q_addr);
        end
    endgenerate

    assign q_pending = !((DISCARD_R0 != 0) && (q_addr == '0)) &&
                       ((|fifo_hit) || (we3_reg && (a3_reg == q_addr)));

endmodule

// File: tb/tb_scalar_writeback_arbiter.sv
// Directed bench for scalar_writeback_arbiter: a per-cycle vector table plus
// hand-written sequences for FIFO backpressure and mid-operation reset.
module tb_scalar_writeback_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        mem_valid;
    logic        mem_ready;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic        we3;
    logic [4:0]  a3;
    logic [31:0] wd3;
    logic [4:0]  q_addr;
    logic        q_pending;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    scalar_writeback_arbiter #(
        .REGISTERS  (32),
        .WIDTH      (32),
        .DEPTH      (4),
        .MAX_WAIT   (3),
        .DISCARD_R0 (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_rd    (mem_rd),
        .mem_data  (mem_data),
        .we3       (we3),
        .a3        (a3),
        .wd3       (wd3),
        .q_addr    (q_addr),
        .q_pending (q_pending)
    );

    typedef struct {
        logic        rst_n;
        logic        av;
        logic [4:0]  ard;
        logic [31:0] ad;
        logic        mv;
        logic [4:0]  mrd;
        logic [31:0] md;
        logic [4:0]  qa;
        logic        e_ar;
        logic        e_mr;
        logic        e_we;
        logic [4:0]  e_a3;
        logic [31:0] e_wd;
        logic        e_qp;
    } vec_t;

    localparam int NVEC = 18;
    vec_t vecs [NVEC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic av, input logic [4:0] ard, input logic [31:0] ad,
                         input logic mv, input logic [4:0] mrd, input logic [31:0] md, input logic [4:0] qa);
        rst_n = r; alu_valid = av; alu_rd = ard; alu_data = ad;
        mem_valid = mv; mem_rd = mrd; mem_data = md; q_addr = qa;
    endtask

    int pushed;
    int retired;
    logic [4:0]  exp_rd [5];
    logic [31:0] exp_d  [5];

    initial begin
        // rst, av, ard, ad, mv, mrd, md, qa | alu_ready, mem_ready, we3, a3, wd3, q_pending
        vecs[0]  = '{0, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 0, 0, 0, 32'h0,        0};
        vecs[1]  = '{1, 1, 5, 32'hABCDEFFF, 0, 0, 32'h0,        5, 1, 1, 0, 0, 32'h0,        0};
        vecs[2]  = '{1, 0, 0, 32'h0,        0, 0, 32'h0,        5, 1, 1, 1, 5, 32'hABCDEFFF, 1};
        vecs[3]  = '{1, 0, 0, 32'h0,        0, 0, 32'h0,        5, 1, 1, 0, 5, 32'hABCDEFFF, 0};
        vecs[4]  = '{1, 0, 0, 32'h0,        1, 1, 32'h11111111, 0, 1, 1, 0, 5, 32'hABCDEFFF, 0};
        vecs[5]  = '{1, 0, 0, 32'h0,        0, 0, 32'h0,        1, 1, 1, 0, 5, 32'hABCDEFFF, 1};
        vecs[6]  = '{1, 0, 0, 32'h0,        0, 0, 32'h0,        1, 1, 1, 1, 1, 32'h11111111, 1};
        vecs[7]  = '{1, 0, 0, 32'h0,        0, 0, 32'h0,        1, 1, 1, 0, 1, 32'h11111111, 0};
        vecs[8]  = '{1, 1, 0, 32'hDEADBEEF, 0, 0, 32'h0,        0, 1, 1, 0, 1, 32'h11111111, 0};
        vecs[9]  = '{1, 0, 0, 32'h0,        0, 0, 32'h0,        0, 1, 1, 0, 1, 32'h11111111, 0};
        vecs[10] = '{1, 1, 2, 32'h22222222, 1, 7, 32'h77777777, 7, 1, 1, 0, 1, 32'h11111111, 0};
        vecs[11] = '{1, 1, 3, 32'h33333333, 0, 0, 32'h0,        7, 1, 1, 1, 2, 32'h22222222, 1};
        vecs[12] = '{1, 1, 4, 32'h44444444, 0, 0, 32'h0,        7, 1, 1, 1, 3, 32'h33333333, 1};
        vecs[13] = '{1, 1, 5, 32'h55555555, 0, 0, 32'h0,        7, 1, 1, 1, 4, 32'h44444444, 1};
        vecs[14] = '{1, 1, 6, 32'h66666666, 0, 0, 32'h0,        7, 0, 1, 1, 5, 32'h55555555, 1};
        vecs[15] = '{1, 1, 6, 32'h66666666, 0, 0, 32'h0,        7, 1, 1, 1, 7, 32'h77777777, 1};
        vecs[16] = '{1, 0, 0, 32'h0,        0, 0, 32'h0,        7, 1, 1, 1, 6, 32'h66666666, 0};
        vecs[17] = '{1, 0, 0, 32'h0,        0, 0, 32'h0,        7, 1, 1, 0, 6, 32'h66666666, 0};

        drive(0, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < NVEC; i++) begin
            @(posedge clk); #1;
            drive(vecs[i].rst_n, vecs[i].av, vecs[i].ard, vecs[i].ad,
                  vecs[i].mv, vecs[i].mrd, vecs[i].md, vecs[i].qa);
            @(negedge clk);
            $display("[TB] vec %0d: alu_ready=%b mem_ready=%b we3=%b a3=%0d wd3=%h q_pending=%b",
                     i, alu_ready, mem_ready, we3, a3, wd3, q_pending);
            chk($sformatf("vec%0d_alu_ready", i), 32'(alu_ready), 32'(vecs[i].e_ar));
            chk($sformatf("vec%0d_mem_ready", i), 32'(mem_ready), 32'(vecs[i].e_mr));
            chk($sformatf("vec%0d_we3", i),       32'(we3),       32'(vecs[i].e_we));
            chk($sformatf("vec%0d_a3", i),        32'(a3),        32'(vecs[i].e_a3));
            chk($sformatf("vec%0d_wd3", i),       wd3,            vecs[i].e_wd);
            chk($sformatf("vec%0d_q_pending", i), 32'(q_pending), 32'(vecs[i].e_qp));
        end

        // Five back-to-back loads against a saturating ALU stream to r20.
        for (int k = 0; k < 5; k++) begin
            exp_rd[k] = 5'(8 + k);
            exp_d[k]  = 32'h10000000 + 32'(k);
        end
        pushed  = 0;
        retired = 0;
        for (int cyc = 0; cyc < 80 && retired < 5; cyc++) begin
            @(posedge clk); #1;
            drive(1, (cyc < 30), 20, 32'hA0A0A0A0, (pushed < 5), 5'(8 + pushed),
                  32'h10000000 + 32'(pushed), 0);
            @(negedge clk);
            $display("[TB] fill cyc %0d: mem_ready=%b alu_ready=%b we3=%b a3=%0d wd3=%h",
                     cyc, mem_ready, alu_ready, we3, a3, wd3);
            if (cyc == 3) chk("fill_ready_before_full", 32'(mem_ready), 32'd1);
            if (cyc == 4) chk("fill_full_blocks_push", 32'(mem_ready), 32'd0);
            if (cyc == 4) chk("fill_force_stalls_alu", 32'(alu_ready), 32'd0);
            if (cyc == 5) chk("fill_fifth_after_pop", 32'(mem_ready), 32'd1);
            if (we3) begin
                if (a3 == 5'd20) begin
                    chk("fill_alu_data", wd3, 32'hA0A0A0A0);
                end else if (retired < 5) begin
                    chk($sformatf("fill_load%0d_addr", retired), 32'(a3), 32'(exp_rd[retired]));
                    chk($sformatf("fill_load%0d_data", retired), wd3, exp_d[retired]);
                    retired++;
                end else begin
                    chk("fill_unexpected_write", 32'(a3), 32'd20);
                end
            end
            if (mem_valid && mem_ready) pushed++;
        end
        chk("fill_pushed_count", 32'(pushed), 32'd5);
        chk("fill_retired_count", 32'(retired), 32'd5);

        // Three loads buffered behind ALU traffic, then a one-cycle reset.
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            drive(1, 1, 21, 32'h21212121, 1, 5'(9 + k), 32'h90000000 + 32'(k), 9);
            @(negedge clk);
        end
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 0, 0, 9);
        @(negedge clk);
        $display("[TB] reset: alu_ready=%b mem_ready=%b q_pending=%b", alu_ready, mem_ready, q_pending);
        chk("rst_alu_ready_low", 32'(alu_ready), 32'd0);
        chk("rst_mem_ready_low", 32'(mem_ready), 32'd0);
        chk("rst_pending_before", 32'(q_pending), 32'd1);
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            drive(1, 0, 0, 0, 0, 0, 0, 5'(9 + (k % 3)));
            @(negedge clk);
            $display("[TB] post-reset %0d: we3=%b a3=%0d wd3=%h mem_ready=%b q_pending=%b",
                     k, we3, a3, wd3, mem_ready, q_pending);
            chk($sformatf("post_rst%0d_we3", k), 32'(we3), 32'd0);
            chk($sformatf("post_rst%0d_pending", k), 32'(q_pending), 32'd0);
            if (k == 0) begin
                chk("post_rst_mem_ready", 32'(mem_ready), 32'd1);
                chk("post_rst_a3", 32'(a3), 32'd0);
                chk("post_rst_wd3", wd3, 32'd0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
